// File: rtl/dram_unpacker_if.sv
// -----------------------------------------------------------------------------
// dram_unpacker_if
// Groups the DRAM read-command port, the DRAM return-FIFO port and the
// unpacked sample stream used by dram_unpacker.
//
//   rd_adx / read_req / read_allowed        : read command handshake
//   has_return_data / get_return_data       : return FIFO status and pop
//   rd_data_return / rd_adx_return          : head of the return FIFO
//   sample_data / sample_valid / sample_ready : 32-bit sample stream
//
// master : the unpacker side (issues reads, pops returns, emits samples)
// slave  : the memory controller / sample consumer side
// -----------------------------------------------------------------------------
interface dram_unpacker_if #(
  parameter int ADDR_W = 27
);
  logic [ADDR_W-1:0] rd_adx;
  logic              read_req;
  logic              read_allowed;
  logic              has_return_data;
  logic              get_return_data;
  logic [127:0]      rd_data_return;
  logic [ADDR_W-1:0] rd_adx_return;
  logic [31:0]       sample_data;
  logic              sample_valid;
  logic              sample_ready;

  modport master (
    output rd_adx, read_req, get_return_data, sample_data, sample_valid,
    input  read_allowed, has_return_data, rd_data_return, rd_adx_return,
           sample_ready
  );

  modport slave (
    input  rd_adx, read_req, get_return_data, sample_data, sample_valid,
    output read_allowed, has_return_data, rd_data_return, rd_adx_return,
           sample_ready
  );
endinterface

// File: rtl/dram_unpacker.sv
// -----------------------------------------------------------------------------
// dram_unpacker
// Reads a run of 128-bit words from DRAM starting at base_adx and unpacks them
// into a stream of 32-bit samples (lane 0 = bits [31:0] first). Keeps at most
// MAX_OUTSTANDING reads in flight, checks that returns come back in address
// order, and supports an abort that drains in-flight returns before idling.
//
// Ports
//   clk, resetn         : clock, synchronous active-low reset
//   start               : pulse, begins a readback when idle
//   abort               : level, ends a readback early
//   base_adx            : address of the first word (sampled on start)
//   sample_count        : number of 32-bit samples (sampled on start)
//   bus (master)        : DRAM read/return ports and sample stream
//   busy                : not idle
//   done                : one-cycle pulse on normal completion
//   aborted             : one-cycle pulse when an abort flush completes
//   adx_error           : sticky, a return address did not match expectation
// -----------------------------------------------------------------------------
module dram_unpacker #(
  parameter int ADDR_W          = 27,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_adx,
  input  logic [31:0]       sample_count,
  dram_unpacker_if.master   bus,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic              adx_error
);

  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [ADDR_W-1:0] WORD_STEP = ADDR_W'(8);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] issue_adx;
  logic [ADDR_W-1:0] expect_adx;
  logic [30:0]       words_total;
  logic [30:0]       words_issued;
  logic [OUT_W-1:0]  outstanding;
  logic [31:0]       samples_left;
  logic [127:0]      hold_data;
  logic [1:0]        lane;
  logic              hold_full;
  logic              adx_error_q;

  logic        accept;
  logic        pop;
  logic        handshake;
  logic        hold_emptying;
  logic        last_sample;
  logic [30:0] words_needed;

  // ceil(sample_count/4) without overflow: whole words plus one if any
  // samples spill into a partial final word.
  assign words_needed = {1'b0, sample_count[31:2]} + 31'(|sample_count[1:0]);

  assign bus.rd_adx   = issue_adx;
  assign bus.read_req = (state == RUN) && !abort &&
                        (words_issued < words_total) &&
                        (outstanding < OUT_W'(MAX_OUTSTANDING));
  assign accept       = bus.read_req && bus.read_allowed;

  assign bus.sample_valid = (state == RUN) && hold_full && !abort;
  assign bus.sample_data  = hold_data[{lane, 5'b0} +: 32];
  assign handshake        = bus.sample_valid && bus.sample_ready;
  assign last_sample      = handshake && (samples_left == 32'd1);
  // The holding register frees up after lane 3, or early on a short final word.
  assign hold_emptying    = handshake && ((lane == 2'd3) || (samples_left == 32'd1));

  assign bus.get_return_data = bus.has_return_data &&
                               (!hold_full || hold_emptying) &&
                               ((state == RUN) || (state == FLUSH));
  assign pop = bus.get_return_data;

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign aborted   = (state == FLUSH) && (outstanding == '0);
  assign adx_error = adx_error_q;

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) state_next = (sample_count == 32'd0) ? DONE : RUN;
      end
      RUN: begin
        if (abort)            state_next = FLUSH;
        else if (last_sample) state_next = DONE;
      end
      FLUSH: begin
        if (outstanding == '0) state_next = IDLE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state        <= IDLE;
      issue_adx    <= '0;
      expect_adx   <= '0;
      words_total  <= '0;
      words_issued <= '0;
      outstanding  <= '0;
      samples_left <= '0;
      hold_data    <= '0;
      lane         <= '0;
      hold_full    <= 1'b0;
      adx_error_q  <= 1'b0;
    end else begin
      state <= state_next;
      if ((state == IDLE) && start) begin
        issue_adx    <= base_adx;
        expect_adx   <= base_adx;
        words_total  <= words_needed;
        words_issued <= '0;
        outstanding  <= '0;
        samples_left <= sample_count;
        lane         <= '0;
        hold_full    <= 1'b0;
        adx_error_q  <= 1'b0;
      end else begin
        if (accept) begin
          issue_adx    <= issue_adx + WORD_STEP;
          words_issued <= words_issued + 31'd1;
        end

        case ({accept, pop})
          2'b10:   outstanding <= outstanding + OUT_W'(1);
          2'b01:   outstanding <= outstanding - OUT_W'(1);
          default: outstanding <= outstanding;
        endcase

        // Returns are expected strictly in issue order; a mismatch is only
        // flagged, the data is still consumed.
        if (pop) begin
          expect_adx <= expect_adx + WORD_STEP;
          if (bus.rd_adx_return != expect_adx) adx_error_q <= 1'b1;
        end

        if (handshake) begin
          samples_left <= samples_left - 32'd1;
          lane         <= lane + 2'd1;
        end

        // Leaving RUN drops whatever is held so a flush can pop freely.
        // A fresh pop overrides the lane advance from a same-cycle handshake.
        if (state_next != RUN) begin
          hold_full <= 1'b0;
        end else if (pop) begin
          hold_data <= bus.rd_data_return;
          lane      <= 2'd0;
          hold_full <= 1'b1;
        end else if (hold_emptying) begin
          hold_full <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_dram_unpacker.sv
// -----------------------------------------------------------------------------
// tb_dram_unpacker
// Directed bench for dram_unpacker: a small DRAM model returns each word with a
// fixed latency, and a monitor collects accepted addresses, popped returns and
// emitted samples. Each word's lanes encode its address and lane number.
// -----------------------------------------------------------------------------
module tb_dram_unpacker;
  localparam int ADDR_W = 27;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              resetn;
  logic              start;
  logic              abort;
  logic [ADDR_W-1:0] base_adx;
  logic [31:0]       sample_count;
  logic              busy, done, aborted, adx_error;

  dram_unpacker_if #(.ADDR_W(ADDR_W)) bus ();

  dram_unpacker #(.ADDR_W(ADDR_W), .MAX_OUTSTANDING(4)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .start        (start),
    .abort        (abort),
    .base_adx     (base_adx),
    .sample_count (sample_count),
    .bus          (bus.master),
    .busy         (busy),
    .done         (done),
    .aborted      (aborted),
    .adx_error    (adx_error)
  );

  typedef struct {
    logic [ADDR_W-1:0] adx;
    int                ready_cyc;
  } rd_t;

  rd_t               mq[$];
  logic [ADDR_W-1:0] acc_log[$];
  logic [31:0]       got[$];
  int cyc = 0, ret_delay = 1, pops = 0, accepts = 0, viol = 0, max_out = 0;
  int done_cnt = 0, aborted_cnt = 0, corrupt_word = -1;
  int tests = 0, fails = 0;

  function automatic logic [31:0] lane_val(logic [ADDR_W-1:0] a, int i);
    logic [1:0] l;
    l = i[1:0];
    return {1'b0, a, l, 2'b01};
  endfunction

  function automatic logic [127:0] word_data(logic [ADDR_W-1:0] a);
    logic [127:0] w;
    for (int i = 0; i < 4; i++) w[32*i +: 32] = lane_val(a, i);
    return w;
  endfunction

  function automatic logic [31:0] exp_sample(logic [ADDR_W-1:0] base, int n);
    logic [ADDR_W-1:0] a;
    a = base + ADDR_W'(8 * (n / 4));
    return lane_val(a, n % 4);
  endfunction

  // Number of collected samples that differ from the expected stream,
  // including a length difference.
  function automatic int count_bad(logic [ADDR_W-1:0] base, int n);
    int bad;
    bad = (got.size() > n) ? got.size() - n : 0;
    for (int i = 0; i < n; i++)
      if (i >= got.size() || got[i] !== exp_sample(base, i)) bad++;
    return bad;
  endfunction

  // DRAM model and monitor: sample on the edge, update 1 time unit later.
  always @(posedge clk) begin
    logic              pop_now, acc_now;
    logic [ADDR_W-1:0] a;
    rd_t               e;
    pop_now = bus.get_return_data;
    acc_now = bus.read_req && bus.read_allowed;
    a       = bus.rd_adx;
    if (bus.read_req && (accepts - pops) >= 4) viol++;
    if (bus.sample_valid && bus.sample_ready) got.push_back(bus.sample_data);
    if (done) done_cnt++;
    if (aborted) aborted_cnt++;
    #1;
    cyc++;
    if (pop_now) begin
      pops++;
      if (mq.size() > 0) void'(mq.pop_front());
    end
    if (acc_now) begin
      accepts++;
      acc_log.push_back(a);
      e.adx = a;
      e.ready_cyc = cyc + ret_delay;
      mq.push_back(e);
    end
    if (accepts - pops > max_out) max_out = accepts - pops;
    if (mq.size() > 0 && mq[0].ready_cyc <= cyc) begin
      bus.has_return_data = 1'b1;
      bus.rd_data_return  = word_data(mq[0].adx);
      bus.rd_adx_return   = (pops == corrupt_word) ? (mq[0].adx ^ ADDR_W'(1)) : mq[0].adx;
    end else begin
      bus.has_return_data = 1'b0;
      bus.rd_data_return  = '0;
      bus.rd_adx_return   = '0;
    end
  end

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic clear_logs(int delay);
    acc_log.delete(); got.delete(); mq.delete();
    accepts = 0; pops = 0; viol = 0; max_out = 0;
    done_cnt = 0; aborted_cnt = 0; corrupt_word = -1; ret_delay = delay;
    bus.has_return_data = 1'b0;
    bus.rd_data_return  = '0;
    bus.rd_adx_return   = '0;
  endtask

  task automatic run(logic [ADDR_W-1:0] base, logic [31:0] count, int max_cyc, bit stall);
    bit ok;
    base_adx = base; sample_count = count; start = 1'b1;
    tick();
    start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      if (done_cnt > 0 || aborted_cnt > 0) begin ok = 1'b1; break; end
      tick();
      if (stall) bus.sample_ready = ~bus.sample_ready;
    end
    bus.sample_ready = 1'b1;
    tests++;
    if (!ok) begin
      fails++;
      $display("[TB] FAIL run_timeout base=%h count=%0d: no completion within %0d cycles", base, count, max_cyc);
    end
    tick(2);
  endtask

  task automatic test_reset();
    resetn = 1'b0; start = 1'b0; abort = 1'b0; base_adx = '0; sample_count = '0;
    bus.read_allowed = 1'b1; bus.sample_ready = 1'b1;
    clear_logs(1);
    tick(2);
    tests++;
    if ({bus.read_req, bus.get_return_data, bus.sample_valid, busy, done, aborted, adx_error} !== 7'b0) begin
      fails++;
      $display("[TB] FAIL reset_flags: got %b expected 0000000",
               {bus.read_req, bus.get_return_data, bus.sample_valid, busy, done, aborted, adx_error});
    end
    tests++;
    if (bus.rd_adx !== '0 || bus.sample_data !== 32'd0) begin
      fails++;
      $display("[TB] FAIL reset_data: rd_adx=%h sample_data=%h expected 0/0", bus.rd_adx, bus.sample_data);
    end
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int bad;
    clear_logs(1);
    run(27'h100, 8, 200, 1'b0);
    tests++;
    if (acc_log.size() !== 2 || acc_log[0] !== 27'h100 || acc_log[1] !== 27'h108) begin
      fails++;
      $display("[TB] FAIL basic_reads: got %0d reads first=%h expected 2 reads 100,108",
               acc_log.size(), (acc_log.size() > 0) ? acc_log[0] : '1);
    end
    bad = count_bad(27'h100, 8);
    tests++;
    if (bad !== 0) begin
      fails++;
      $display("[TB] FAIL basic_samples: %0d bad of %0d got, expected 0 bad of 8", bad, got.size());
    end
    tests++;
    if (done_cnt !== 1 || busy !== 1'b0 || adx_error !== 1'b0) begin
      fails++;
      $display("[TB] FAIL basic_done: done_cnt=%0d busy=%b adx_error=%b expected 1/0/0", done_cnt, busy, adx_error);
    end
  endtask

  task automatic test_partial();
    int bad;
    clear_logs(1);
    run(27'h200, 5, 300, 1'b1);
    tests++;
    if (acc_log.size() !== 2) begin
      fails++;
      $display("[TB] FAIL partial_reads: got %0d expected 2", acc_log.size());
    end
    bad = count_bad(27'h200, 5);
    tests++;
    if (bad !== 0 || done_cnt !== 1) begin
      fails++;
      $display("[TB] FAIL partial_samples: bad=%0d got=%0d done=%0d expected 0/5/1", bad, got.size(), done_cnt);
    end
  endtask

  task automatic test_outstanding();
    int bad;
    clear_logs(20);
    run(27'h1000, 40, 2000, 1'b0);
    tests++;
    if (acc_log.size() !== 10 || viol !== 0 || max_out !== 4) begin
      fails++;
      $display("[TB] FAIL outstanding_limit: reads=%0d viol=%0d max_out=%0d expected 10/0/4",
               acc_log.size(), viol, max_out);
    end
    bad = count_bad(27'h1000, 40);
    tests++;
    if (bad !== 0 || done_cnt !== 1) begin
      fails++;
      $display("[TB] FAIL outstanding_samples: bad=%0d got=%0d done=%0d expected 0/40/1", bad, got.size(), done_cnt);
    end
  endtask

  task automatic test_wrap();
    int bad;
    clear_logs(1);
    run(27'h7FFFFF8, 8, 200, 1'b0);
    tests++;
    if (acc_log.size() !== 2 || acc_log[0] !== 27'h7FFFFF8 || acc_log[1] !== 27'h0) begin
      fails++;
      $display("[TB] FAIL wrap_adx: got %0d reads second=%h expected 2 reads second=0000000",
               acc_log.size(), (acc_log.size() > 1) ? acc_log[1] : '1);
    end
    bad = count_bad(27'h7FFFFF8, 8);
    tests++;
    if (bad !== 0) begin
      fails++;
      $display("[TB] FAIL wrap_samples: bad=%0d got=%0d expected 0/8", bad, got.size());
    end
  endtask

  task automatic test_zero_count();
    clear_logs(1);
    run(27'h500, 0, 50, 1'b0);
    tests++;
    if (acc_log.size() !== 0 || got.size() !== 0 || done_cnt !== 1 || busy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL zero_count: reads=%0d samples=%0d done=%0d busy=%b expected 0/0/1/0",
               acc_log.size(), got.size(), done_cnt, busy);
    end
  endtask

  task automatic test_adx_error();
    int bad;
    clear_logs(1);
    corrupt_word = 1;
    run(27'h300, 12, 300, 1'b0);
    bad = count_bad(27'h300, 12);
    tests++;
    if (adx_error !== 1'b1 || bad !== 0 || done_cnt !== 1) begin
      fails++;
      $display("[TB] FAIL adx_error_set: adx_error=%b bad=%0d done=%0d expected 1/0/1", adx_error, bad, done_cnt);
    end
    tick(5);
    tests++;
    if (adx_error !== 1'b1) begin
      fails++;
      $display("[TB] FAIL adx_error_sticky: got %b expected 1", adx_error);
    end
    clear_logs(1);
    run(27'h340, 4, 200, 1'b0);
    tests++;
    if (adx_error !== 1'b0) begin
      fails++;
      $display("[TB] FAIL adx_error_clear: got %b expected 0", adx_error);
    end
  endtask

  task automatic test_abort();
    bit ok;
    clear_logs(5);
    bus.sample_ready = 1'b0;
    bus.read_allowed = 1'b1;
    base_adx = 27'h400; sample_count = 40; start = 1'b1;
    tick();
    start = 1'b0;
    tick(3);
    bus.read_allowed = 1'b0;
    tests++;
    if (acc_log.size() !== 3) begin
      fails++;
      $display("[TB] FAIL abort_setup_reads: got %0d expected 3", acc_log.size());
    end
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (pops >= 1) begin ok = 1'b1; break; end
      tick();
    end
    tests++;
    if (!ok || pops !== 1) begin
      fails++;
      $display("[TB] FAIL abort_setup_pop: pops=%0d expected 1", pops);
    end
    abort = 1'b1;
    #1;
    tests++;
    if (bus.read_req !== 1'b0 || bus.sample_valid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL abort_gating: read_req=%b sample_valid=%b expected 0/0", bus.read_req, bus.sample_valid);
    end
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (aborted_cnt > 0) begin ok = 1'b1; break; end
      tick();
    end
    abort = 1'b0;
    tick(2);
    tests++;
    if (!ok || pops !== 3 || aborted_cnt !== 1 || done_cnt !== 0 || busy !== 1'b0 || got.size() !== 0) begin
      fails++;
      $display("[TB] FAIL abort_flush: pops=%0d aborted=%0d done=%0d busy=%b samples=%0d expected 3/1/0/0/0",
               pops, aborted_cnt, done_cnt, busy, got.size());
    end
    bus.sample_ready = 1'b1;
    bus.read_allowed = 1'b1;
  endtask

  task automatic test_back_to_back();
    int bad;
    bit ok;
    clear_logs(1);
    abort = 1'b1;
    tick(3);
    abort = 1'b0;
    tests++;
    if (busy !== 1'b0 || aborted_cnt !== 0) begin
      fails++;
      $display("[TB] FAIL idle_abort: busy=%b aborted=%0d expected 0/0", busy, aborted_cnt);
    end
    base_adx = 27'h600; sample_count = 8; start = 1'b1;
    tick();
    start = 1'b0;
    tick(2);
    base_adx = 27'h900; sample_count = 4; start = 1'b1;
    tick();
    start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (done_cnt > 0) begin ok = 1'b1; break; end
      tick();
    end
    tick(2);
    bad = count_bad(27'h600, 8);
    tests++;
    if (!ok || bad !== 0 || acc_log.size() !== 2 || acc_log[1] !== 27'h608) begin
      fails++;
      $display("[TB] FAIL start_ignored: bad=%0d reads=%0d done=%0d expected 0/2/1", bad, acc_log.size(), done_cnt);
    end
    clear_logs(1);
    run(27'h700, 4, 200, 1'b0);
    bad = count_bad(27'h700, 4);
    tests++;
    if (bad !== 0 || acc_log.size() !== 1 || done_cnt !== 1) begin
      fails++;
      $display("[TB] FAIL back_to_back: bad=%0d reads=%0d done=%0d expected 0/1/1", bad, acc_log.size(), done_cnt);
    end
  endtask

  task automatic test_reset_midrun();
    int pops_at;
    int bad;
    clear_logs(10);
    base_adx = 27'hA00; sample_count = 40; start = 1'b1;
    tick();
    start = 1'b0;
    tick(3);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    pops_at = pops;
    tick(20);
    tests++;
    if (pops !== pops_at || busy !== 1'b0 || bus.get_return_data !== 1'b0 || bus.read_req !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_midrun: pops %0d->%0d busy=%b get=%b read_req=%b expected no pops and 0/0/0",
               pops_at, pops, busy, bus.get_return_data, bus.read_req);
    end
    clear_logs(1);
    run(27'hB00, 4, 200, 1'b0);
    bad = count_bad(27'hB00, 4);
    tests++;
    if (bad !== 0 || done_cnt !== 1) begin
      fails++;
      $display("[TB] FAIL reset_recover: bad=%0d done=%0d expected 0/1", bad, done_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_partial();
    test_outstanding();
    test_wrap();
    test_zero_count();
    test_adx_error();
    test_abort();
    test_back_to_back();
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
